// File: rtl/led_seq_pkg.sv
// Shared types and constants for the RGB LED sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_seq_pkg;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_RED   = 3'd1,
    MODE_GREEN = 3'd2,
    MODE_BLUE  = 3'd3,
    MODE_WHITE = 3'd4,
    MODE_CYCLE = 3'd5
  } mode_t;

  typedef enum logic [1:0] {
    STEP_RED   = 2'd0,
    STEP_GREEN = 2'd1,
    STEP_BLUE  = 2'd2
  } step_col_t;

  // One bit per LED channel.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam logic [3:0] BRIGHT_RESET = 4'd8;
  localparam logic [3:0] BRIGHT_MAX   = 4'd15;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:   return MODE_RED;
      MODE_RED:   return MODE_GREEN;
      MODE_GREEN: return MODE_BLUE;
      MODE_BLUE:  return MODE_WHITE;
      MODE_WHITE: return MODE_CYCLE;
      default:    return MODE_OFF;
    endcase
  endfunction

  function automatic step_col_t next_step(input step_col_t c);
    case (c)
      STEP_RED:   return STEP_GREEN;
      STEP_GREEN: return STEP_BLUE;
      default:    return STEP_RED;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises and debounces one active-low button, emitting a one-cycle press pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles to the pulse.
// Backpressure: none; the pulse is not held.
// Ports: clk, reset_i (sync, active-high), btn_i (raw, active-low),
//        press_o (one-cycle pulse on an accepted 1->0 transition).
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000
) (
  input  logic clk,
  input  logic reset_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    armed_d = armed_q;
    fill_d  = {fill_q[0], 1'b1};

    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
        press_d = level_q & ~sync2_q & armed_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end

    // The sync flops come out of reset as "released", so a button held
    // through reset would look like a fresh press. Only arm once a real
    // released sample has made it through the synchroniser.
    if (fill_q[1] && sync2_q) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_sequencer.sv
// RGB LED sequencer: mode FSM, 16-level PWM brightness and a timed colour cycle.
// Latency: 1 cycle from PWM counter/mode/brightness to LED pins; mode_o is combinational from the mode register.
// Backpressure: none; button presses are applied on the cycle their pulse is high.
// Ports: clk, reset_i (sync, active-high), button_i[2:0] (active-low: mode, up, down),
//        red_o/green_o/blue_o (active-low LED drive), mode_o (current mode).
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter int unsigned STEP_CYCLES     = 6000000
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [2:0] button_i,
  output logic       red_o,
  output logic       green_o,
  output logic       blue_o,
  output logic [2:0] mode_o
);

  localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  logic [2:0] press_pulse;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_i(reset_i),
      .btn_i  (button_i[i]),
      .press_o(press_pulse[i])
    );
  end

  mode_t         mode_q, mode_d;
  logic [3:0]    bright_q, bright_d;
  logic [3:0]    pwm_q;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  step_col_t     step_col_q, step_col_d;
  rgb_t          en;
  rgb_t          lit_d;
  rgb_t          led_n_q;

  always_comb begin
    mode_d = press_pulse[0] ? next_mode(mode_q) : mode_q;

    // Up and down together cancel out.
    bright_d = bright_q;
    if (press_pulse[1] && !press_pulse[2] && (bright_q != BRIGHT_MAX)) begin
      bright_d = bright_q + 4'd1;
    end else if (press_pulse[2] && !press_pulse[1] && (bright_q != 4'd0)) begin
      bright_d = bright_q - 4'd1;
    end

    // The step state only runs while staying in CYCLE; entering, leaving
    // or being in any other mode holds it at the start of the red step.
    step_cnt_d = '0;
    step_col_d = STEP_RED;
    if ((mode_q == MODE_CYCLE) && (mode_d == MODE_CYCLE)) begin
      if (step_cnt_q == STEP_LAST) begin
        step_col_d = next_step(step_col_q);
      end else begin
        step_cnt_d = step_cnt_q + SW'(1);
        step_col_d = step_col_q;
      end
    end

    en = '0;
    case (mode_q)
      MODE_RED:   en.r = 1'b1;
      MODE_GREEN: en.g = 1'b1;
      MODE_BLUE:  en.b = 1'b1;
      MODE_WHITE: en   = '1;
      MODE_CYCLE: begin
        case (step_col_q)
          STEP_RED:   en.r = 1'b1;
          STEP_GREEN: en.g = 1'b1;
          STEP_BLUE:  en.b = 1'b1;
          default:    en   = '0;
        endcase
      end
      default:    en = '0;
    endcase

    // pwm < brightness gives a duty of brightness/16; brightness 0 never lights.
    lit_d.r = en.r & (pwm_q < bright_q);
    lit_d.g = en.g & (pwm_q < bright_q);
    lit_d.b = en.b & (pwm_q < bright_q);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      mode_q     <= MODE_OFF;
      bright_q   <= BRIGHT_RESET;
      pwm_q      <= 4'd0;
      step_cnt_q <= '0;
      step_col_q <= STEP_RED;
      led_n_q    <= '1;
    end else begin
      mode_q     <= mode_d;
      bright_q   <= bright_d;
      pwm_q      <= pwm_q + 4'd1;
      step_cnt_q <= step_cnt_d;
      step_col_q <= step_col_d;
      led_n_q    <= ~lit_d;
    end
  end

  assign red_o   = led_n_q.r;
  assign green_o = led_n_q.g;
  assign blue_o  = led_n_q.b;
  assign mode_o  = mode_q;

endmodule
